if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives ce/addr of the combinational
//  instruction ROM, and captures the returned word into the IF/ID pipeline
//  register. Sits directly upstream of inst_rom and feeds the decode stage.
//  Handles stall, flush (exception redirect) and branch redirect.
// PARAMETERS
//  ADDR_W    32            PC / ROM address width (matches InstAddrBus)
//  INST_W    32            instruction width (matches InstBus)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous reset, active low
//  stall_if      in   1       hold PC this cycle
//  stall_id      in   1       decode stalled; hold IF/ID register
//  flush         in   1       discard in-flight fetch, redirect to flush_pc
//  flush_pc      in   ADDR_W  exception/flush target
//  branch_flag   in   1       redirect to branch_target
//  branch_target in   ADDR_W  branch destination
//  rom_ce        out  1       ROM chip enable (1 = enabled)
//  rom_addr      out  ADDR_W  ROM byte address (= pc)
//  rom_inst      in   INST_W  ROM data, valid in the same cycle as rom_addr
//  id_pc         out  ADDR_W  PC of instruction presented to decode
//  id_inst       out  INST_W  instruction presented to decode
//  id_valid      out  1       id_pc/id_inst hold a real fetched instruction
//  id_addr_err   out  1       fetch address misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0,
//    id_valid=0, id_addr_err=0. Takes effect immediately, mid-operation too.
//  - rom_ce is registered: 0 during reset, 1 from the first rising edge after
//    rst_n deasserts, then stays 1. rom_addr = pc, combinational from pc reg.
//  - PC next-state, priority high->low:
//    rom_ce==0 -> RESET_PC (first fetch is at RESET_PC)
//    flush -> flush_pc; stall_if -> hold; branch_flag -> branch_target;
//    else pc+4, modulo 2^ADDR_W (32'hFFFF_FFFC wraps to 0).
//  - branch_flag is ignored while stall_if=1; branch source holds it until
//    stall releases. flush wins over stall_if and branch_flag.
//  - IF/ID register, priority high->low:
//    flush -> id_pc=0, id_inst=0, id_valid=0 (bubble)
//    stall_if & !stall_id -> bubble (id_inst=0, id_valid=0)
//    stall_id -> hold all id_* outputs
//    else id_pc<=pc, id_inst<=rom_inst, id_valid<=rom_ce.
//  - Latency: instruction at pc appears on id_* one edge after pc is driven.
//  - Branch taken at edge N: fetch at branch_target on cycle N+1; the word
//    fetched in cycle N (delay slot) still enters IF/ID normally.
//  - rom_ce=0 cycle yields id_valid=0, id_inst=0 regardless of rom_inst.
// CONFIGURATION
//  IF_ADDR_CHK_EN defined:
//   - pc[1:0]!=0 at capture -> id_addr_err=1, id_inst=0, id_valid=1,
//     id_pc=pc (full misaligned value); pc still advances per priority rules.
//   - id_addr_err cleared by flush/bubble, held by stall_id like other id_*.
//  IF_ADDR_CHK_EN undefined:
//   - id_addr_err tied 1'b0; pc[1:0] ignored (ROM indexes addr[..:2]).
// TESTING
//  1. Reset release, no stalls, ROM[i]=i+1 -> rom_ce 0 then 1; id_pc 0,4,8,
//     id_inst 1,2,3 on consecutive edges, id_valid=1 from 2nd edge.
//  2. stall_if=1,stall_id=0 for 2 cycles at pc=8 -> pc holds 8, two bubbles
//     (id_valid=0,id_inst=0), then id_pc=8 resumes.
//  3. stall_id=1 at id_pc=4 with stall_if=1 -> id_* hold 4/ROM[1] for the
//     stall duration; no instruction lost or duplicated on release.
//  4. branch_flag=1,target=0x40 at pc=0x10 -> id_pc sequence 0x10,0x40,0x44;
//     same with stall_if=1 for 1 cycle -> redirect deferred until release.
//  5. flush=1,flush_pc=0x180 with branch_flag=1 and stall_if=1 same cycle ->
//     next pc=0x180, id_valid=0 next edge, then id_pc=0x180.
//  6. pc=0xFFFF_FFFC -> next pc 0; rst_n pulse mid-run -> all outputs zero
//     asynchronously, pc=RESET_PC; with IF_ADDR_CHK_EN, target 0x42 ->
//     id_addr_err=1, id_inst=0, id_pc=0x42.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Owns the PC, drives the combinational instruction ROM (rom_ce/rom_addr) and
// captures the returned word into the IF/ID pipeline register. Handles stall,
// flush (exception redirect) and branch redirect.
// Optional feature: define IF_ADDR_CHK_EN to flag misaligned fetch addresses
// on id_addr_err. When undefined, id_addr_err is tied low and pc[1:0] is
// ignored.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_addr_err
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  logic              rom_ce_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] next_pc_s;

  logic [ADDR_W-1:0] id_pc_r;
  logic [INST_W-1:0] id_inst_r;
  logic              id_valid_r;
  logic              id_addr_err_r;

  logic [ADDR_W-1:0] id_pc_s;
  logic [INST_W-1:0] id_inst_s;
  logic              id_valid_s;
  logic              id_addr_err_s;
  logic              misaligned_s;

  assign rom_ce   = rom_ce_r;
  assign rom_addr = pc_r;
  assign id_pc    = id_pc_r;
  assign id_inst  = id_inst_r;
  assign id_valid = id_valid_r;

`ifdef IF_ADDR_CHK_EN
  assign misaligned_s = (pc_r[1:0] != 2'b00);
  assign id_addr_err  = id_addr_err_r;
`else
  // Without the check the ROM indexes addr[..:2], so low bits are don't-care.
  assign misaligned_s = 1'b0;
  assign id_addr_err  = 1'b0;
`endif

  // ROM enable: low in reset, rises on the first edge after release and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ce_r <= 1'b0;
    end else begin
      rom_ce_r <= 1'b1;
    end
  end

  // Next-PC selection: restart, flush, stall hold, branch, sequential.
  always_comb begin
    next_pc_s = pc_r + PC_STEP;
    if (!rom_ce_r) begin
      // First enabled cycle fetches from RESET_PC.
      next_pc_s = RESET_PC;
    end else if (flush) begin
      next_pc_s = flush_pc;
    end else if (stall_if) begin
      // A pending branch is deliberately ignored here; its source holds it.
      next_pc_s = pc_r;
    end else if (branch_flag) begin
      next_pc_s = branch_target;
    end else begin
      next_pc_s = pc_r + PC_STEP;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // IF/ID next value: flush bubble, stall bubble, decode hold, or capture.
  always_comb begin
    id_pc_s       = id_pc_r;
    id_inst_s     = id_inst_r;
    id_valid_s    = id_valid_r;
    id_addr_err_s = id_addr_err_r;
    if (flush) begin
      id_pc_s       = {ADDR_W{1'b0}};
      id_inst_s     = {INST_W{1'b0}};
      id_valid_s    = 1'b0;
      id_addr_err_s = 1'b0;
    end else if (stall_if && !stall_id) begin
      // Fetch is held but decode moves on: feed it a bubble.
      id_pc_s       = {ADDR_W{1'b0}};
      id_inst_s     = {INST_W{1'b0}};
      id_valid_s    = 1'b0;
      id_addr_err_s = 1'b0;
    end else if (stall_id) begin
      id_pc_s       = id_pc_r;
      id_inst_s     = id_inst_r;
      id_valid_s    = id_valid_r;
      id_addr_err_s = id_addr_err_r;
    end else begin
      id_pc_s    = pc_r;
      id_valid_s = rom_ce_r;
      if (rom_ce_r && misaligned_s) begin
        // Misaligned fetch: keep the real PC for the exception, drop the word.
        id_inst_s     = {INST_W{1'b0}};
        id_addr_err_s = 1'b1;
      end else if (rom_ce_r) begin
        id_inst_s     = rom_inst;
        id_addr_err_s = 1'b0;
      end else begin
        // ROM disabled: whatever is on rom_inst is not a real instruction.
        id_inst_s     = {INST_W{1'b0}};
        id_addr_err_s = 1'b0;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_r       <= {ADDR_W{1'b0}};
      id_inst_r     <= {INST_W{1'b0}};
      id_valid_r    <= 1'b0;
      id_addr_err_r <= 1'b0;
    end else begin
      id_pc_r       <= id_pc_s;
      id_inst_r     <= id_inst_s;
      id_valid_r    <= id_valid_s;
      id_addr_err_r <= id_addr_err_s;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed per-cycle vectors with hand-computed
// expected values pushed to a scoreboard queue, checked by a separate monitor.
// ROM model: word at byte address a is (a >> 2) + 1.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_addr_err;

  typedef struct {
    int          idx;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    bit          chk_pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  if_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .stall_id(stall_id),
    .flush(flush), .flush_pc(flush_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .id_addr_err(id_addr_err)
  );

  assign rom_inst = {2'b00, rom_addr[31:2]} + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: after each rising edge, compare DUT state against the queued expectation.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("s%0d.rom_ce", e.idx), {31'd0, rom_ce}, {31'd0, e.ce});
      chk($sformatf("s%0d.rom_addr", e.idx), rom_addr, e.addr);
      chk($sformatf("s%0d.id_valid", e.idx), {31'd0, id_valid}, {31'd0, e.valid});
      chk($sformatf("s%0d.id_inst", e.idx), id_inst, e.inst);
      chk($sformatf("s%0d.id_addr_err", e.idx), {31'd0, id_addr_err}, {31'd0, e.err});
      if (e.chk_pc) chk($sformatf("s%0d.id_pc", e.idx), id_pc, e.pc);
    end
  end

  // One clock: drive inputs, then queue what IF/ROM must show after the edge.
  task automatic cyc(input logic sif, input logic sid, input logic fl, input logic [31:0] fpc,
                     input logic br, input logic [31:0] tgt,
                     input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc,
                     input logic [31:0] e_inst, input logic e_err, input bit e_chkpc);
    exp_t e;
    stall_if = sif; stall_id = sid; flush = fl; flush_pc = fpc;
    branch_flag = br; branch_target = tgt;
    @(posedge clk);
    step++;
    e.idx = step; e.ce = 1'b1; e.addr = e_addr; e.valid = e_valid; e.pc = e_pc;
    e.inst = e_inst; e.err = e_err; e.chk_pc = e_chkpc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] e_addr, input logic [31:0] e_pc, input logic [31:0] e_inst);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, e_addr, 1'b1, e_pc, e_inst, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".rom_ce"}, {31'd0, rom_ce}, 32'd0);
    chk({tag, ".rom_addr"}, rom_addr, 32'd0);
    chk({tag, ".id_pc"}, id_pc, 32'd0);
    chk({tag, ".id_inst"}, id_inst, 32'd0);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, ".id_addr_err"}, {31'd0, id_addr_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
    flush_pc = 32'd0; branch_flag = 1'b0; branch_target = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Startup: first edge enables ROM (no valid yet), then 0,4,8 -> 1,2,3.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(32'h04, 32'h00, 32'h1);
    idle(32'h08, 32'h04, 32'h2);

    // Fetch stall at pc=8: two bubbles, PC held, then 8 resumes.
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h08, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h08, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(32'h0C, 32'h08, 32'h3);
    idle(32'h10, 32'h0C, 32'h4);
    idle(32'h14, 32'h10, 32'h5);

    // Decode stall with fetch stall: id_* hold 0x10/5, no loss on release.
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h14, 1'b1, 32'h10, 32'h5, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h14, 1'b1, 32'h10, 32'h5, 1'b0, 1'b1);
    idle(32'h18, 32'h14, 32'h6);

    // Branch at pc=0x18 to 0x40: delay slot 0x18 still enters, then 0x40,0x44.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 32'h40, 1'b1, 32'h18, 32'h7, 1'b0, 1'b1);
    idle(32'h44, 32'h40, 32'h11);
    idle(32'h48, 32'h44, 32'h12);

    // Branch during fetch stall is deferred until the stall releases.
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 32'h48, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 32'h80, 1'b1, 32'h48, 32'h13, 1'b0, 1'b1);
    idle(32'h84, 32'h80, 32'h21);

    // Flush beats stall and branch: redirect to 0x180, bubble, then 0x180.
    cyc(1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h40, 32'h180, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(32'h184, 32'h180, 32'h61);
    idle(32'h188, 32'h184, 32'h62);

    // PC wrap: 0xFFFF_FFFC + 4 -> 0.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h188, 32'h63, 1'b0, 1'b1);
    idle(32'h0, 32'hFFFF_FFFC, 32'h4000_0000);
    idle(32'h4, 32'h0, 32'h1);

    // Misaligned branch target 0x42.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h42, 32'h42, 1'b1, 32'h4, 32'h2, 1'b0, 1'b1);
`ifdef IF_ADDR_CHK_EN
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h46, 1'b1, 32'h42, 32'h0, 1'b1, 1'b1);
`else
    idle(32'h46, 32'h42, 32'h11);
`endif
    // Flush clears the error flag and realigns to 0.
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(32'h4, 32'h0, 32'h1);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(32'h04, 32'h00, 32'h1);

    // Bounded drain of the scoreboard.
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
